// File: rtl/aquaflex_pkg.sv
// aquaflex shared types: FSM states, route codes, peristaltic phase table.
// AQUAFLEX_FLUSH_EN adds the FLUSH state to the sequencer.
package aquaflex_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETTLE   = 3'd1,
    ST_LOAD     = 3'd2,
    ST_MIX      = 3'd3,
    ST_DISPENSE = 3'd4,
`ifdef AQUAFLEX_FLUSH_EN
    ST_FLUSH    = 3'd5,
`endif
    ST_DONE     = 3'd6
  } state_e;

  localparam logic [2:0] SRC_B = 3'd0;
  localparam logic [2:0] SRC_C = 3'd1;
  localparam logic [2:0] SRC_D = 3'd2;
  localparam logic [2:0] SRC_E = 3'd3;
  localparam logic [2:0] SRC_F = 3'd4;

  localparam logic [1:0] DST_H = 2'd0;
  localparam logic [1:0] DST_I = 2'd1;
  localparam logic [1:0] DST_J = 2'd2;

  localparam logic [2:0] PUMP_CLOSED = 3'b111;

  localparam logic [2:0] PERI_SEQ [0:5] = '{
    3'b100, 3'b110, 3'b010,
    3'b011, 3'b001, 3'b101
  };

  function automatic logic [4:0] srcMask(input logic [2:0] src);
    return 5'b00001 << src;
  endfunction

  function automatic logic [2:0] dstMask(input logic [1:0] dst);
    return 3'b001 << dst;
  endfunction

endpackage

// File: rtl/aquaflex_flow_sequencer_if.sv
// Command handshake bundle for the aquaflex flow sequencer.
// master issues transfers, slave (the sequencer) accepts them.
interface aquaflex_flow_sequencer_if #(
  parameter int VOL_W = 8,
  parameter int MIX_W = 12
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [2:0]       cmd_src;
  logic [1:0]       cmd_dst;
  logic [VOL_W-1:0] cmd_vol;
  logic [MIX_W-1:0] cmd_mix;

  modport master (
    output cmd_valid, cmd_src, cmd_dst,
    output cmd_vol, cmd_mix,
    input  cmd_ready
  );

  modport slave (
    input  cmd_valid, cmd_src, cmd_dst,
    input  cmd_vol, cmd_mix,
    output cmd_ready
  );
endinterface

// File: rtl/aquaflex_peri_pump.sv
// Peristaltic pump driver: steps the 6-phase valve pattern for N strokes.
// start (re)launches a run, halt closes the pump at once.
module aquaflex_peri_pump
  import aquaflex_pkg::*;
#(
  parameter int STEP_CYCLES = 4,
  parameter int VOL_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt,
  input  logic [VOL_W-1:0] strokes,
  output logic [2:0]       pattern,
  output logic             stroke_done
);

  localparam int HW = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;

  logic             running;
  logic [HW-1:0]    holdCnt;
  logic [2:0]       phase;
  logic [VOL_W-1:0] strokeCnt;
  logic [VOL_W-1:0] target;
  logic             stepEnd;
  logic             strokeEnd;

  assign stepEnd   = holdCnt == HW'(STEP_CYCLES - 1);
  assign strokeEnd = stepEnd && (phase == 3'd5);
  assign stroke_done = running && strokeEnd &&
                       (strokeCnt == target - VOL_W'(1));

  // Phase hold, phase index and stroke counters; pattern registered.
  always_ff @(posedge clk) begin
    if (rst || halt) begin
      running   <= 1'b0;
      holdCnt   <= '0;
      phase     <= '0;
      strokeCnt <= '0;
      target    <= '0;
      pattern   <= PUMP_CLOSED;
    end else if (start) begin
      running   <= 1'b1;
      holdCnt   <= '0;
      phase     <= '0;
      strokeCnt <= '0;
      target    <= strokes;
      pattern   <= PERI_SEQ[0];
    end else if (running) begin
      if (stroke_done) begin
        running   <= 1'b0;
        holdCnt   <= '0;
        phase     <= '0;
        strokeCnt <= target;
        pattern   <= PUMP_CLOSED;
      end else if (strokeEnd) begin
        holdCnt   <= '0;
        phase     <= '0;
        strokeCnt <= strokeCnt + VOL_W'(1);
        pattern   <= PERI_SEQ[0];
      end else if (stepEnd) begin
        holdCnt   <= '0;
        phase     <= phase + 3'd1;
        pattern   <= PERI_SEQ[phase + 3'd1];
      end else begin
        holdCnt   <= holdCnt + HW'(1);
      end
    end
  end

endmodule

// File: rtl/aquaflex_flow_sequencer.sv
// Transfer sequencer for aquaflex_3b: settle, load, mix, dispense.
// Define AQUAFLEX_FLUSH_EN to add a B->J flush stroke after dispense.
module aquaflex_flow_sequencer
  import aquaflex_pkg::*;
#(
  parameter int STEP_CYCLES   = 4,
  parameter int SETTLE_CYCLES = 8,
  parameter int VOL_W         = 8,
  parameter int MIX_W         = 12
) (
  input  logic       clk,
  input  logic       rst,
  aquaflex_flow_sequencer_if.slave cmd,
  input  logic       abort,
  output logic [4:0] in_valve,
  output logic [2:0] out_valve,
  output logic [2:0] pump_a,
  output logic [2:0] pump_c,
  output logic       mixer_en,
  output logic       busy,
  output logic       done,
  output logic       err
);

  localparam int SW = $clog2(SETTLE_CYCLES + 1);
  localparam int CW = (MIX_W > SW) ? MIX_W : SW;

  state_e           state, stateN;
  logic [CW-1:0]    cnt, cntN;
  logic [2:0]       srcR;
  logic [1:0]       dstR;
  logic [VOL_W-1:0] volR;
  logic [MIX_W-1:0] mixR;
  logic [VOL_W-1:0] strokesA, strokesC;
  logic             accept, cmdBad, halt;
  logic             startA, startC, doneA, doneC;
  logic [4:0]       inN;
  logic [2:0]       outN;
  logic             mixN, doneN, errN;

  assign cmd.cmd_ready = (state == ST_IDLE);
  assign busy   = (state != ST_IDLE);
  assign accept = cmd.cmd_valid && cmd.cmd_ready;
  assign cmdBad = (cmd.cmd_src > SRC_F) ||
                  (cmd.cmd_dst > DST_J) ||
                  (cmd.cmd_vol == '0);
  assign halt   = abort && (state != ST_IDLE);

  // Next state, phase counters and next registered actuator values.
  always_comb begin
    stateN   = state;
    cntN     = cnt;
    startA   = 1'b0;
    startC   = 1'b0;
    strokesA = volR;
    strokesC = volR;
    errN     = 1'b0;
    inN      = '0;
    outN     = '0;
    mixN     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (accept) begin
          if (cmdBad) begin
            errN = 1'b1;
          end else begin
            stateN = ST_SETTLE;
            cntN   = '0;
          end
        end
      end
      ST_SETTLE: begin
        if (cnt == CW'(SETTLE_CYCLES - 1)) begin
          stateN = ST_LOAD;
          startA = 1'b1;
          cntN   = '0;
        end else begin
          cntN = cnt + CW'(1);
        end
      end
      ST_LOAD: begin
        if (doneA) begin
          if (mixR == '0) begin
            stateN = ST_DISPENSE;
            startC = 1'b1;
          end else begin
            stateN = ST_MIX;
            cntN   = '0;
          end
        end
      end
      ST_MIX: begin
        if (cnt == CW'(mixR) - CW'(1)) begin
          stateN = ST_DISPENSE;
          startC = 1'b1;
          cntN   = '0;
        end else begin
          cntN = cnt + CW'(1);
        end
      end
      ST_DISPENSE: begin
        if (doneC) begin
`ifdef AQUAFLEX_FLUSH_EN
          stateN   = ST_FLUSH;
          startA   = 1'b1;
          startC   = 1'b1;
          strokesA = VOL_W'(1);
          strokesC = VOL_W'(1);
`else
          stateN = ST_DONE;
`endif
        end
      end
`ifdef AQUAFLEX_FLUSH_EN
      ST_FLUSH: begin
        if (doneA) stateN = ST_DONE;
      end
`endif
      ST_DONE: stateN = ST_IDLE;
      default: stateN = ST_IDLE;
    endcase
    if (halt) begin
      stateN = ST_IDLE;
      cntN   = '0;
      errN   = 1'b1;
    end
    unique case (stateN)
      ST_SETTLE, ST_LOAD:
        inN = srcMask(state == ST_IDLE ? cmd.cmd_src : srcR);
      ST_MIX: mixN = 1'b1;
      ST_DISPENSE: outN = dstMask(dstR);
`ifdef AQUAFLEX_FLUSH_EN
      ST_FLUSH: begin
        inN  = srcMask(SRC_B);
        outN = dstMask(DST_J);
      end
`endif
      default: ;
    endcase
    doneN = (stateN == ST_DONE);
  end

  // State and phase counter register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= '0;
    end else begin
      state <= stateN;
      cnt   <= cntN;
    end
  end

  // Capture command fields on an accepted, valid command.
  always_ff @(posedge clk) begin
    if (rst) begin
      srcR <= '0;
      dstR <= '0;
      volR <= '0;
      mixR <= '0;
    end else if (accept && !cmdBad) begin
      srcR <= cmd.cmd_src;
      dstR <= cmd.cmd_dst;
      volR <= cmd.cmd_vol;
      mixR <= cmd.cmd_mix;
    end
  end

  // Registered valve, mixer and status pulse outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_valve  <= '0;
      out_valve <= '0;
      mixer_en  <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
    end else begin
      in_valve  <= inN;
      out_valve <= outN;
      mixer_en  <= mixN;
      done      <= doneN;
      err       <= errN;
    end
  end

  aquaflex_peri_pump #(
    .STEP_CYCLES (STEP_CYCLES),
    .VOL_W       (VOL_W)
  ) pumpA (
    .clk         (clk),
    .rst         (rst),
    .start       (startA),
    .halt        (halt),
    .strokes     (strokesA),
    .pattern     (pump_a),
    .stroke_done (doneA)
  );

  aquaflex_peri_pump #(
    .STEP_CYCLES (STEP_CYCLES),
    .VOL_W       (VOL_W)
  ) pumpC (
    .clk         (clk),
    .rst         (rst),
    .start       (startC),
    .halt        (halt),
    .strokes     (strokesC),
    .pattern     (pump_c),
    .stroke_done (doneC)
  );

endmodule
